// File: rtl/orv64_param_pkg.sv
// Global ORV64 implementation parameters shared across the core.
package orv64_param_pkg;

    localparam int ORV64_N_CYCLE_INT_MUL = 4;

endpackage

// File: rtl/orv64_typedef_pkg.sv
// ORV64 shared type definitions for the integer multiply path.
package orv64_typedef_pkg;

    typedef enum logic [2:0] {
        ORV64_MUL_OP_MUL,
        ORV64_MUL_OP_MULH,
        ORV64_MUL_OP_MULHSU,
        ORV64_MUL_OP_MULHU,
        ORV64_MUL_OP_MULW
    } orv64_mul_op_t;

    typedef enum logic [2:0] {
        ORV64_MUL_TYPE_NONE,
        ORV64_MUL_TYPE_L,
        ORV64_MUL_TYPE_HSS,
        ORV64_MUL_TYPE_HSU,
        ORV64_MUL_TYPE_HUU,
        ORV64_MUL_TYPE_W
    } orv64_mul_type_t;

    function automatic orv64_mul_type_t orv64_mul_op_to_type(input orv64_mul_op_t op);
        orv64_mul_type_t t;
        case (op)
            ORV64_MUL_OP_MUL:    t = ORV64_MUL_TYPE_L;
            ORV64_MUL_OP_MULH:   t = ORV64_MUL_TYPE_HSS;
            ORV64_MUL_OP_MULHSU: t = ORV64_MUL_TYPE_HSU;
            ORV64_MUL_OP_MULHU:  t = ORV64_MUL_TYPE_HUU;
            ORV64_MUL_OP_MULW:   t = ORV64_MUL_TYPE_W;
            default:             t = ORV64_MUL_TYPE_NONE;
        endcase
        return t;
    endfunction

    // MUL and MULW results sit in the low half (W is already sign-extended there).
    function automatic logic orv64_mul_op_takes_high(input orv64_mul_op_t op);
        return (op == ORV64_MUL_OP_MULH) || (op == ORV64_MUL_OP_MULHSU) ||
               (op == ORV64_MUL_OP_MULHU);
    endfunction

endpackage

// File: rtl/orv64_mul_seq_ctrl.sv
// Sequencing controller between the issue stage and the fixed-latency multiplier:
// latches one request, pulses start, waits for completion and holds the response.
module orv64_mul_seq_ctrl
    import orv64_param_pkg::*;
    import orv64_typedef_pkg::*;
#(
    parameter int N_CYCLE    = ORV64_N_CYCLE_INT_MUL,
    parameter int LAT_MARGIN = 2
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req_valid,
    output logic            req_ready,
    input  orv64_mul_op_t   req_op,
    input  logic [63:0]     req_rs1,
    input  logic [63:0]     req_rs2,
    input  logic [4:0]      req_rd_idx,

    input  logic            flush,
    output logic            busy,
    output logic            lat_err,

    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [63:0]     resp_data,
    output logic [4:0]      resp_rd_idx,

    output logic            mul_start_pulse,
    output logic [63:0]     mul_rs1,
    output logic [63:0]     mul_rs2,
    output orv64_mul_type_t mul_type,
    input  logic            mul_complete,
    input  logic [63:0]     mul_rdh,
    input  logic [63:0]     mul_rdl
);

    localparam int CNT_SAT = N_CYCLE + LAT_MARGIN;
    localparam int CNT_W   = $clog2(CNT_SAT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic            kill_q, kill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            lat_err_q, lat_err_d;
    logic [63:0]     rs1_q, rs2_q, resp_data_q;
    orv64_mul_op_t   op_q;
    logic [4:0]      rd_q;

    logic accept;
    logic capture;

    assign accept  = req_valid && (state_q == IDLE) && !flush;
    // A result is kept only if no flush was seen since START, including this cycle.
    assign capture = (state_q == WAIT) && mul_complete && !kill_q && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            kill_q    <= 1'b0;
            cnt_q     <= '0;
            lat_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            cnt_q     <= cnt_d;
            lat_err_q <= lat_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        cnt_d     = '0;
        lat_err_d = lat_err_q;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (accept) state_d = START;
            end
            START: begin
                if (flush) kill_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (flush) kill_d = 1'b1;
                cnt_d = (cnt_q == CNT_W'(CNT_SAT)) ? cnt_q : cnt_q + 1'b1;
                if (mul_complete) begin
                    state_d = (kill_q || flush) ? IDLE : DONE;
                    kill_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(CNT_SAT - 1)) begin
                    lat_err_d = 1'b1;
                end
            end
            DONE: begin
                if (flush || resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (state_q == IDLE);
        busy            = (state_q != IDLE);
        resp_valid      = (state_q == DONE);
        mul_start_pulse = (state_q == START);
        mul_type        = ((state_q == START) || (state_q == WAIT)) ?
                          orv64_mul_op_to_type(op_q) : ORV64_MUL_TYPE_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            op_q        <= ORV64_MUL_OP_MUL;
            rd_q        <= '0;
            resp_data_q <= '0;
        end else begin
            if (accept) begin
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                op_q  <= req_op;
                rd_q  <= req_rd_idx;
            end
            if (capture) begin
                resp_data_q <= orv64_mul_op_takes_high(op_q) ? mul_rdh : mul_rdl;
            end
        end
    end

    assign mul_rs1     = rs1_q;
    assign mul_rs2     = rs2_q;
    assign resp_data   = resp_data_q;
    assign resp_rd_idx = rd_q;
    assign lat_err     = lat_err_q;

endmodule
